mips_multicycle_ctrl: RTL and testbench

- Control unit for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback as a Moore FSM.
- Drives the mux selects and write enables of the datapath.
- Generates the 3-bit alucontrol code consumed directly by the ALU, and takes the ALU's zero flag back for branch resolution.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 58 +++++
 rtl/mips_multicycle_ctrl_if.sv | 29 ++
 rtl/mips_multicycle_ctrl_aludec.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// These cover FSM states, opcodes, funct codes, ALU codes and mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11,
    StBneEx   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } aluop_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlNop = 3'b011;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAluRes = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and datapath (slave).
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc, pcen, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc, pcen, alucontrol
  );
endinterface

// File: rtl/mips_multicycle_ctrl_aludec.sv
// Combinational ALU decoder: maps aluop and funct to the 3-bit alucontrol code.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = AluCtlNop;
    case (aluop)
      AluOpAdd: alucontrol = AluCtlAdd;
      AluOpSub: alucontrol = AluCtlSub;
      AluOpFunct: begin
        case (funct)
          FunctAdd: alucontrol = AluCtlAdd;
          FunctSub: alucontrol = AluCtlSub;
          FunctAnd: alucontrol = AluCtlAnd;
          FunctOr:  alucontrol = AluCtlOr;
          FunctSlt: alucontrol = AluCtlSlt;
          default:  alucontrol = AluCtlNop;
        endcase
      end
      default: alucontrol = AluCtlNop;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-FSM control unit for the multicycle MIPS datapath.
// Optional bne support is enabled by defining MIPS_MULTICYCLE_CTRL_BNE_EN.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pcwrite;
  logic   branch;
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
  logic   branchn;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = StFetch;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = SrcBReg;
    bus.pcsrc    = PcSrcAluRes;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = AluOpAdd;
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
    branchn      = 1'b0;
`endif
    case (state_q)
      StFetch: begin
        bus.alusrcb = SrcBFour;
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
        state_d     = StDecode;
      end
      StDecode: begin
        bus.alusrcb = SrcBImmSh;
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
          OpBne:      state_d = StBneEx;
`endif
          default:    state_d = StFetch;  // unknown opcode retires as a NOP
        endcase
      end
      StMemAdr: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SrcBImm;
        state_d     = (bus.op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        bus.iord = 1'b1;
        state_d  = StMemWb;
      end
      StMemWb: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      StMemWr: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      StRtypeEx: begin
        bus.alusrca = 1'b1;
        aluop       = AluOpFunct;
        state_d     = StRtypeWb;
      end
      StRtypeWb: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      StBeqEx: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = PcSrcAluOut;
        aluop       = AluOpSub;
        branch      = 1'b1;
      end
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
      StBneEx: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = PcSrcAluOut;
        aluop       = AluOpSub;
        branchn     = 1'b1;
      end
`endif
      StAddiEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SrcBImm;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        bus.regwrite = 1'b1;
      end
      StJEx: begin
        bus.pcsrc = PcSrcJump;
        pcwrite   = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Branch target was latched in ALUOut during decode; load it on the edge leaving BEQEX.
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
  assign bus.pcen = pcwrite | (branch & bus.zero) | (branchn & ~bus.zero);
`else
  assign bus.pcen = pcwrite | (branch & bus.zero);
`endif

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; bne checks follow MIPS_MULTICYCLE_CTRL_BNE_EN.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol}
  logic [14:0] obs;
  assign obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol};

  localparam logic [14:0] EFetch   = 15'b0_0_1_0_0_0_0_01_00_1_010;
  localparam logic [14:0] EDecode  = 15'b0_0_0_0_0_0_0_11_00_0_010;
  localparam logic [14:0] EMemAdr  = 15'b0_0_0_0_0_0_1_10_00_0_010;
  localparam logic [14:0] EMemRd   = 15'b1_0_0_0_0_0_0_00_00_0_010;
  localparam logic [14:0] EMemWb   = 15'b0_0_0_0_1_1_0_00_00_0_010;
  localparam logic [14:0] EMemWr   = 15'b1_1_0_0_0_0_0_00_00_0_010;
  localparam logic [14:0] ERtypeEx = 15'b0_0_0_0_0_0_1_00_00_0_010;
  localparam logic [14:0] ERtypeWb = 15'b0_0_0_1_0_1_0_00_00_0_010;
  localparam logic [14:0] EBrTaken = 15'b0_0_0_0_0_0_1_00_01_1_110;
  localparam logic [14:0] EBrNot   = 15'b0_0_0_0_0_0_1_00_01_0_110;
  localparam logic [14:0] EAddiEx  = 15'b0_0_0_0_0_0_1_10_00_0_010;
  localparam logic [14:0] EAddiWb  = 15'b0_0_0_0_0_1_0_00_00_0_010;
  localparam logic [14:0] EJEx     = 15'b0_0_0_0_0_0_0_00_10_1_010;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.op = 6'b000000;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    #1;
    tests++;
    if (obs !== EFetch) begin
      fails++;
      $display("FAIL reset_state: got %b want %b", obs, EFetch);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tick;
    tick;
    tests++;
    if (obs !== ERtypeEx) begin
      fails++;
      $display("FAIL pre_reset_rtypeex: got %b want %b", obs, ERtypeEx);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== EFetch) begin
      fails++;
      $display("FAIL reset_abort: got %b want %b", obs, EFetch);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== EFetch) begin
      fails++;
      $display("FAIL post_release: got %b want %b", obs, EFetch);
    end
    tick;
    tests++;
    if (obs !== EDecode) begin
      fails++;
      $display("FAIL no_partial_wb: got %b want %b", obs, EDecode);
    end
    tick;
    tick;
    tick;
    tests++;
    if (obs !== EFetch) begin
      fails++;
      $display("FAIL reset_recover: got %b want %b", obs, EFetch);
    end
  endtask

  task automatic test_rtype;
    logic [14:0] seq[$];
    bus.op = 6'b000000;
    bus.funct = 6'b100000;
    seq = '{EFetch, EDecode, ERtypeEx, ERtypeWb, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL rtype_add step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] seq[$];
    bus.op = 6'b100011;
    seq = '{EFetch, EDecode, EMemAdr, EMemRd, EMemWb, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL lw step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
    bus.op = 6'b101011;
    seq = '{EFetch, EDecode, EMemAdr, EMemWr, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL sw step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
    bus.op = 6'b001000;
    seq = '{EFetch, EDecode, EAddiEx, EAddiWb, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL addi step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [14:0] seq[$];
    bus.op = 6'b000100;
    bus.zero = 1'b1;
    seq = '{EFetch, EDecode, EBrTaken, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL beq_taken step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
    bus.zero = 1'b0;
    seq = '{EFetch, EDecode, EBrNot, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL beq_not_taken step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_jump_unknown;
    logic [14:0] seq[$];
    bus.op = 6'b000010;
    seq = '{EFetch, EDecode, EJEx, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL jump step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
    bus.op = 6'b111111;
    seq = '{EFetch, EDecode, EFetch};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) tick;
      tests++;
      if (obs !== seq[i]) begin
        fails++;
        $display("FAIL unknown_op step %0d: got %b want %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_aludec;
    logic [5:0]  functs[6];
    logic [2:0]  codes[6];
    logic [14:0] exp;
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    codes  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};
    bus.op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      bus.funct = functs[k];
      #1;
      tests++;
      if (obs !== EFetch) begin
        fails++;
        $display("FAIL aludec_fetch funct=%b: got %b want %b", functs[k], obs, EFetch);
      end
      tick;
      tick;
      exp = ERtypeEx;
      exp[2:0] = codes[k];
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL aludec funct=%b: got %b want %b", functs[k], obs, exp);
      end
      tick;
      tick;
    end
    bus.funct = 6'b100000;
  endtask

  task automatic test_bne;
    logic [14:0] seq[$];
    bus.op = 6'b000101;
    for (int z = 0; z < 2; z++) begin
      bus.zero = (z == 1);
`ifdef MIPS_MULTICYCLE_CTRL_BNE_EN
      seq = '{EFetch, EDecode, (z == 1) ? EBrNot : EBrTaken, EFetch};
`else
      seq = '{EFetch, EDecode, EFetch};
`endif
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) tick;
        tests++;
        if (obs !== seq[i]) begin
          fails++;
          $display("FAIL bne zero=%0d step %0d: got %b want %b", z, i, obs, seq[i]);
        end
      end
    end
    bus.zero = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_rtype;
    test_back_to_back;
    test_branch;
    test_jump_unknown;
    test_aludec;
    test_bne;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
